// File: rtl/axi_sync_fwft_fifo.sv
// Single-clock FIFO for the AXI4 slave write-back path.
// Inferred simple dual-port RAM plus control; optional first-word-fall-through
// read mode, sticky overflow/underflow flags and a unified water level.
// In FWFT mode the output register is part of the storage, so the level
// counts RAM words plus the presented head word.
module axi_sync_fwft_fifo #(
   parameter int DATA_WIDTH       = 32,
   parameter int DEPTH_WIDTH      = 9,
   parameter int FWFT             = 0,
   parameter int ALMOST_FULL_NUM  = 508,
   parameter int ALMOST_EMPTY_NUM = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   input  logic                   wr_en,
   output logic                   wr_full,
   output logic                   almost_full,
   input  logic                   rd_en,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   rd_empty,
   output logic                   almost_empty,
   output logic [DEPTH_WIDTH:0]   water_level,
   output logic                   overflow,
   output logic                   underflow,
   input  logic                   clr_err
);

   localparam int                 DEPTH    = 1 << DEPTH_WIDTH;
   localparam logic [DEPTH_WIDTH:0] C_ZERO = {(DEPTH_WIDTH+1){1'b0}};
   localparam logic [DEPTH_WIDTH:0] C_ONE  = {{DEPTH_WIDTH{1'b0}}, 1'b1};
   localparam logic [DEPTH_WIDTH:0] C_CAP  = {1'b1, {DEPTH_WIDTH{1'b0}}};
   localparam logic [DEPTH_WIDTH:0] C_AF   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
   localparam logic [DEPTH_WIDTH:0] C_AE   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
   localparam logic [DEPTH_WIDTH-1:0] C_PTR_ONE = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};

   // Thresholds that can never be reached, or that overlap, are a configuration bug.
   generate
      if ((ALMOST_FULL_NUM > (1 << DEPTH_WIDTH)) || (ALMOST_EMPTY_NUM >= ALMOST_FULL_NUM)) begin : g_bad_thresholds
         $error("axi_sync_fwft_fifo: illegal ALMOST_FULL_NUM/ALMOST_EMPTY_NUM");
      end
   endgenerate

   logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
   logic [DATA_WIDTH-1:0]  r_rd_data;
   logic [DEPTH_WIDTH-1:0] r_wptr;
   logic [DEPTH_WIDTH-1:0] r_rptr;
   logic [DEPTH_WIDTH:0]   r_level;
   logic [DEPTH_WIDTH:0]   r_ram_cnt;
   logic                   r_out_valid;
   logic                   r_full;
   logic                   r_empty;
   logic                   r_afull;
   logic                   r_aempty;
   logic                   r_ovf;
   logic                   r_udf;

   logic                   w_wr_acc;
   logic                   w_rd_acc;
   logic                   w_ram_rd;
   logic                   w_valid_nxt;
   logic                   w_empty_nxt;
   logic [DEPTH_WIDTH:0]   w_level_nxt;
   logic [DEPTH_WIDTH:0]   w_ram_cnt_nxt;

   // Acceptance always uses the registered flags.
   assign w_wr_acc = wr_en & ~r_full;
   assign w_rd_acc = rd_en & ~r_empty;

   // Decide when a RAM word is fetched into the output register.
   always_comb begin
      w_ram_rd    = 1'b0;
      w_valid_nxt = r_out_valid;
      if (FWFT != 0) begin
         if ((r_ram_cnt != C_ZERO) && (!r_out_valid || w_rd_acc)) begin
            w_ram_rd    = 1'b1;
            w_valid_nxt = 1'b1;
         end else if (w_rd_acc) begin
            w_valid_nxt = 1'b0;
         end else begin
            w_valid_nxt = r_out_valid;
         end
      end else begin
         w_ram_rd    = w_rd_acc;
         w_valid_nxt = 1'b0;
      end
   end

   // Next level (user-visible) and next RAM occupancy.
   always_comb begin
      w_level_nxt   = r_level;
      w_ram_cnt_nxt = r_ram_cnt;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_level_nxt = r_level + C_ONE;
         2'b01:   w_level_nxt = r_level - C_ONE;
         default: w_level_nxt = r_level;
      endcase
      case ({w_wr_acc, w_ram_rd})
         2'b10:   w_ram_cnt_nxt = r_ram_cnt + C_ONE;
         2'b01:   w_ram_cnt_nxt = r_ram_cnt - C_ONE;
         default: w_ram_cnt_nxt = r_ram_cnt;
      endcase
      if (FWFT != 0) begin
         w_empty_nxt = ~w_valid_nxt;
      end else begin
         w_empty_nxt = (w_level_nxt == C_ZERO);
      end
   end

   // RAM write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wptr] <= wr_data;
      end
   end

   // RAM read port feeding the output data register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data <= {DATA_WIDTH{1'b0}};
      end else if (w_ram_rd) begin
         r_rd_data <= r_mem[r_rptr];
      end
   end

   // Pointers, level and registered status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr      <= {DEPTH_WIDTH{1'b0}};
         r_rptr      <= {DEPTH_WIDTH{1'b0}};
         r_level     <= C_ZERO;
         r_ram_cnt   <= C_ZERO;
         r_out_valid <= 1'b0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_afull     <= 1'b0;
         r_aempty    <= 1'b1;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + C_PTR_ONE;
         if (w_ram_rd) r_rptr <= r_rptr + C_PTR_ONE;
         r_level     <= w_level_nxt;
         r_ram_cnt   <= w_ram_cnt_nxt;
         r_out_valid <= w_valid_nxt;
         r_full      <= (w_level_nxt == C_CAP);
         r_empty     <= w_empty_nxt;
         r_afull     <= (w_level_nxt >= C_AF);
         r_aempty    <= (w_level_nxt <= C_AE);
      end
   end

   // Sticky error flags; a new event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= (wr_en & r_full)  | (r_ovf & ~clr_err);
         r_udf <= (rd_en & r_empty) | (r_udf & ~clr_err);
      end
   end

   assign wr_full      = r_full;
   assign almost_full  = r_afull;
   assign rd_data      = r_rd_data;
   assign rd_empty     = r_empty;
   assign almost_empty = r_aempty;
   assign water_level  = r_level;
   assign overflow     = r_ovf;
   assign underflow    = r_udf;

endmodule

// File: tb/tb_axi_sync_fwft_fifo.sv
// Directed bench for axi_sync_fwft_fifo: one standard-read and one FWFT
// instance, both 16 words deep, driven one after the other.
module tb_axi_sync_fwft_fifo;

   logic        clk = 1'b0;
   int          n_checks = 0;
   int          n_fail   = 0;

   // Standard-read instance signals
   logic        rst0, wr_en0, rd_en0, clr_err0;
   logic [31:0] wr_data0, rd_data0;
   logic        wr_full0, almost_full0, rd_empty0, almost_empty0, overflow0, underflow0;
   logic [4:0]  water_level0;

   // FWFT instance signals
   logic        rst1, wr_en1, rd_en1, clr_err1;
   logic [31:0] wr_data1, rd_data1;
   logic        wr_full1, almost_full1, rd_empty1, almost_empty1, overflow1, underflow1;
   logic [4:0]  water_level1;

   always #5 clk = ~clk;

   axi_sync_fwft_fifo #(
      .DATA_WIDTH(32), .DEPTH_WIDTH(4), .FWFT(0), .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(4)
   ) u_dut0 (
      .clk(clk), .rst(rst0), .wr_data(wr_data0), .wr_en(wr_en0), .wr_full(wr_full0),
      .almost_full(almost_full0), .rd_en(rd_en0), .rd_data(rd_data0), .rd_empty(rd_empty0),
      .almost_empty(almost_empty0), .water_level(water_level0), .overflow(overflow0),
      .underflow(underflow0), .clr_err(clr_err0)
   );

   axi_sync_fwft_fifo #(
      .DATA_WIDTH(32), .DEPTH_WIDTH(4), .FWFT(1), .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(4)
   ) u_dut1 (
      .clk(clk), .rst(rst1), .wr_data(wr_data1), .wr_en(wr_en1), .wr_full(wr_full1),
      .almost_full(almost_full1), .rd_en(rd_en1), .rd_data(rd_data1), .rd_empty(rd_empty1),
      .almost_empty(almost_empty1), .water_level(water_level1), .overflow(overflow1),
      .underflow(underflow1), .clr_err(clr_err1)
   );

   // Count one comparison and report it if it differs.
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sampling and driving happen 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst0 = 1'b1; wr_en0 = 1'b0; rd_en0 = 1'b0; clr_err0 = 1'b0; wr_data0 = 32'd0;
      rst1 = 1'b1; wr_en1 = 1'b0; rd_en1 = 1'b0; clr_err1 = 1'b0; wr_data1 = 32'd0;
      tick();
      rst0 = 1'b0; rst1 = 1'b0;

      // ---------------- standard read mode ----------------
      check_eq("rst_full",   32'(wr_full0),      32'd0);
      check_eq("rst_afull",  32'(almost_full0),  32'd0);
      check_eq("rst_empty",  32'(rd_empty0),     32'd1);
      check_eq("rst_aempty", 32'(almost_empty0), 32'd1);
      check_eq("rst_level",  32'(water_level0),  32'd0);
      check_eq("rst_ovf",    32'(overflow0),     32'd0);
      check_eq("rst_udf",    32'(underflow0),    32'd0);
      check_eq("rst_data",   rd_data0,           32'd0);

      // Fill with 1..16; flags follow the level in the same cycle.
      for (int i = 1; i <= 16; i++) begin
         wr_en0 = 1'b1; wr_data0 = 32'(i);
         tick();
         check_eq("fill_level",  32'(water_level0),  32'(i));
         check_eq("fill_empty",  32'(rd_empty0),     32'd0);
         check_eq("fill_aempty", 32'(almost_empty0), (i <= 4)  ? 32'd1 : 32'd0);
         check_eq("fill_afull",  32'(almost_full0),  (i >= 14) ? 32'd1 : 32'd0);
         check_eq("fill_full",   32'(wr_full0),      (i == 16) ? 32'd1 : 32'd0);
      end

      // 17th write is dropped and flagged.
      wr_data0 = 32'h11;
      tick();
      check_eq("ovf_set",   32'(overflow0),    32'd1);
      check_eq("ovf_level", 32'(water_level0), 32'd16);
      wr_en0 = 1'b0; clr_err0 = 1'b1;
      tick();
      clr_err0 = 1'b0;
      check_eq("ovf_clr",   32'(overflow0),    32'd0);

      // Read and write together while full: read wins, write dropped.
      wr_en0 = 1'b1; wr_data0 = 32'h11; rd_en0 = 1'b1;
      tick();
      wr_en0 = 1'b0;
      check_eq("full_rw_data",  rd_data0,           32'd1);
      check_eq("full_rw_level", 32'(water_level0),  32'd15);
      check_eq("full_rw_ovf",   32'(overflow0),     32'd1);
      check_eq("full_rw_full",  32'(wr_full0),      32'd0);

      // Drain the rest; data arrives one edge after each accepted rd_en.
      for (int i = 2; i <= 16; i++) begin
         tick();
         check_eq("drain_data",  rd_data0,          32'(i));
         check_eq("drain_level", 32'(water_level0), 32'(16 - i));
      end
      rd_en0 = 1'b0;
      check_eq("drain_empty", 32'(rd_empty0), 32'd1);
      tick();
      check_eq("hold_data", rd_data0, 32'd16);

      // Read on empty sets underflow; data holds.
      rd_en0 = 1'b1;
      tick();
      rd_en0 = 1'b0;
      check_eq("udf_set",   32'(underflow0),   32'd1);
      check_eq("udf_data",  rd_data0,          32'd16);
      check_eq("udf_level", 32'(water_level0), 32'd0);

      // Level 10 then a single-cycle reset.
      for (int i = 0; i < 10; i++) begin
         wr_en0 = 1'b1; wr_data0 = 32'h100 + 32'(i);
         tick();
      end
      wr_en0 = 1'b0;
      check_eq("pre_rst_level", 32'(water_level0), 32'd10);
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
      check_eq("mid_rst_level",  32'(water_level0),  32'd0);
      check_eq("mid_rst_empty",  32'(rd_empty0),     32'd1);
      check_eq("mid_rst_aempty", 32'(almost_empty0), 32'd1);
      check_eq("mid_rst_data",   rd_data0,           32'd0);
      check_eq("mid_rst_udf",    32'(underflow0),    32'd0);

      // Post-reset round trip, including a simultaneous read/write at level 1.
      wr_en0 = 1'b1; wr_data0 = 32'h200;
      tick();
      wr_data0 = 32'h201; rd_en0 = 1'b1;
      tick();
      wr_en0 = 1'b0;
      check_eq("rw_mid_data",  rd_data0,          32'h200);
      check_eq("rw_mid_level", 32'(water_level0), 32'd1);
      tick();
      rd_en0 = 1'b0;
      check_eq("post_rst_data",  rd_data0,          32'h201);
      check_eq("post_rst_empty", 32'(rd_empty0),    32'd1);

      // ---------------- FWFT mode ----------------
      check_eq("f_rst_empty", 32'(rd_empty1), 32'd1);
      check_eq("f_rst_data",  rd_data1,       32'd0);

      // Single word falls through two edges after the write.
      wr_en1 = 1'b1; wr_data1 = 32'hA5;
      tick();
      wr_en1 = 1'b0;
      check_eq("f_one_empty1", 32'(rd_empty1),    32'd1);
      check_eq("f_one_level1", 32'(water_level1), 32'd1);
      tick();
      check_eq("f_one_empty2", 32'(rd_empty1),    32'd0);
      check_eq("f_one_data",   rd_data1,          32'hA5);
      tick();
      check_eq("f_one_hold",   rd_data1,          32'hA5);
      rd_en1 = 1'b1;
      tick();
      rd_en1 = 1'b0;
      check_eq("f_pop_empty",  32'(rd_empty1),    32'd1);
      check_eq("f_pop_level",  32'(water_level1), 32'd0);
      check_eq("f_pop_udf",    32'(underflow1),   32'd0);

      // Continuous streaming: after two cycles of fill the pipe runs gap-free.
      for (int c = 0; c < 1000; c++) begin
         wr_en1 = 1'b1; rd_en1 = 1'b1; wr_data1 = 32'(c);
         if (c == 1) check_eq("f_strm_fill", 32'(rd_empty1), 32'd1);
         if (c >= 2) begin
            check_eq("f_strm_empty", 32'(rd_empty1),    32'd0);
            check_eq("f_strm_level", 32'(water_level1), 32'd2);
            check_eq("f_strm_data",  rd_data1,          32'(c - 2));
         end
         tick();
      end
      wr_en1 = 1'b0;
      check_eq("f_tail_data0",  rd_data1,          32'd998);
      tick();
      check_eq("f_tail_data1",  rd_data1,          32'd999);
      check_eq("f_tail_level1", 32'(water_level1), 32'd1);
      tick();
      rd_en1 = 1'b0;
      check_eq("f_tail_empty",  32'(rd_empty1),    32'd1);
      check_eq("f_tail_level0", 32'(water_level1), 32'd0);
      check_eq("f_strm_udf",    32'(underflow1),   32'd1);
      clr_err1 = 1'b1;
      tick();
      clr_err1 = 1'b0;
      check_eq("f_udf_clr",     32'(underflow1),   32'd0);

      // Read+write on empty: write taken, underflow set; set beats clear.
      wr_en1 = 1'b1; rd_en1 = 1'b1; wr_data1 = 32'h55;
      tick();
      wr_en1 = 1'b0;
      check_eq("f_ew_udf",   32'(underflow1),   32'd1);
      check_eq("f_ew_level", 32'(water_level1), 32'd1);
      check_eq("f_ew_empty", 32'(rd_empty1),    32'd1);
      clr_err1 = 1'b1;
      tick();
      clr_err1 = 1'b0;
      check_eq("f_setwin_udf",   32'(underflow1),   32'd1);
      check_eq("f_setwin_empty", 32'(rd_empty1),    32'd0);
      check_eq("f_setwin_data",  rd_data1,          32'h55);
      check_eq("f_setwin_level", 32'(water_level1), 32'd1);
      tick();
      rd_en1 = 1'b0;
      check_eq("f_last_level", 32'(water_level1), 32'd0);
      check_eq("f_last_empty", 32'(rd_empty1),    32'd1);
      check_eq("f_last_ovf",   32'(overflow1),    32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_sync_fwft_fifo.md
Name: axi_sync_fwft_fifo

Overview:
- Single-clock, parametrised FIFO for the AXI4 slave write-back path.
- Replaces dual-clock instances where both sides share one clock domain.
- Adds over the previous generation: selectable first-word-fall-through (FWFT) read mode, sticky overflow/underflow error flags with clear, and one unified water level.
- Storage is an inferred simple dual-port RAM plus control logic, all inside this block.

Parameters:
- DATA_WIDTH, 32: width of wr_data and rd_data.
- DEPTH_WIDTH, 9: capacity is 2^DEPTH_WIDTH words (512).
- FWFT, 0: 0 = standard read (data one cycle after rd_en); 1 = first-word-fall-through.
- ALMOST_FULL_NUM, 508: almost_full asserts when level >= this value.
- ALMOST_EMPTY_NUM, 4: almost_empty asserts when level <= this value.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_data  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- wr_full  out  1  level == 2^DEPTH_WIDTH.
- almost_full  out  1  level >= ALMOST_FULL_NUM.
- rd_en  in  1  read request (FWFT=1: pop/acknowledge).
- rd_data  out  DATA_WIDTH  read data.
- rd_empty  out  1  no readable word.
- almost_empty  out  1  level <= ALMOST_EMPTY_NUM.
- water_level  out  DEPTH_WIDTH+1  words accepted and not yet popped.
- overflow  out  1  sticky: write attempted while wr_full.
- underflow  out  1  sticky: read attempted while rd_empty.
- clr_err  in  1  clears overflow and underflow.

Behaviour:
- Reset (rst=1 at an edge):
  - Pointers and level go to 0.
  - wr_full=0, almost_full=0, rd_empty=1, almost_empty=1, overflow=0, underflow=0, rd_data=0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all stored words; outputs take reset values at the next edge.
- Write acceptance: a write is accepted iff wr_en & !wr_full, using the registered wr_full. An accepted write stores to RAM[wptr] and increments wptr, wrapping modulo 2^DEPTH_WIDTH.
- Read acceptance: a read is accepted iff rd_en & !rd_empty, using the registered rd_empty.
- Level accounting:
  - Level is +1 on an accepted write only, -1 on an accepted read only, unchanged on both or neither.
  - Level never exceeds 2^DEPTH_WIDTH.
  - All flags are registered and consistent with water_level in the same cycle.
- Capacity: exactly 2^DEPTH_WIDTH in both modes. In FWFT the output-stage word counts toward the level.
- FWFT=0 read timing:
  - rd_data updates at the edge after an accepted read and holds otherwise.
  - rd_empty deasserts in the cycle after the accepting write edge.
- FWFT=1 read timing:
  - Head word is presented on rd_data whenever rd_empty=0; rd_en consumes it.
  - An internal prefetch moves the next RAM word into the output register; back-to-back pops sustain 1 word/clk.
  - rd_empty deasserts 2 edges after the first write into an empty FIFO.
  - rd_data holds while rd_en=0.
- Simultaneous events:
  - rd_en & wr_en while full: read accepted, write dropped, overflow set.
  - rd_en & wr_en while empty: write accepted, read ignored, underflow set.
  - rd_en & wr_en otherwise: both accepted, level unchanged.
- Error flags:
  - overflow is set by wr_en & wr_full; underflow is set by rd_en & rd_empty.
  - Both flags clear on clr_err.
  - If a new error event and clr_err occur in the same cycle, set wins.
- Threshold sanity: ALMOST_FULL_NUM <= 2^DEPTH_WIDTH and ALMOST_EMPTY_NUM < ALMOST_FULL_NUM. A violation is an elaboration error.

Test Plan:
- FWFT=0, DEPTH_WIDTH=4: write 0x1..0x10 -> wr_full=1 at level 16; almost_full from level 508-clamped param=14; 17th write dropped, overflow=1; reads return 0x1..0x10 in order, each one cycle after rd_en.
- FWFT=1: single write 0xA5 into empty FIFO -> rd_empty=0 two edges later with rd_data=0xA5 before rd_en; pop -> rd_empty=1, level=0.
- FWFT=1, continuous wr_en and rd_en for 1000 cycles with an incrementing pattern -> no gaps after fill; level constant; data in order; pointers wrap cleanly.
- Empty FIFO, rd_en=1 and wr_en=1 with 0x55 -> underflow=1, level=1; clr_err asserted with another rd_en on empty -> underflow stays 1.
- Level 10, rst pulse for 1 clk -> next cycle level=0, rd_empty=1, rd_data=0, flags cleared; a subsequent write/read round-trip returns only post-reset data.
- Sweep ALMOST_EMPTY_NUM=4: levels 4->5 -> almost_empty 1->0 in the same cycle water_level reads 5.
